// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit radix-2 restoring divider for MIPS DIV/DIVU
// Quotient goes to LO and remainder to HI; holds the pipeline via stall_o while busy.
module div_unit #(
    parameter int         WIDTH       = 32,
    parameter logic [7:0] EXE_DIV_OP  = 8'b0001_1010,
    parameter logic [7:0] EXE_DIVU_OP = 8'b0001_1011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       alucontrol,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall_o,
    output logic             ready,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [5:0]       cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic             sign_quo_q;
    logic             sign_rem_q;
    logic             ready_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;

    logic             is_div_op;
    logic             is_signed;
    logic             accept;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        is_signed = (alucontrol == EXE_DIV_OP);
        is_div_op = is_signed | (alucontrol == EXE_DIVU_OP);
        accept    = (state_q == IDLE) & start & ~cancel & is_div_op;
        stall_o   = accept | (state_q == BUSY);
        a_abs     = (is_signed & a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
        b_abs     = (is_signed & b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
    end

    // One restoring step: the remainder stays below the divisor, so 33 bits cover the trial difference.
    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, div_q};
        rem_nx  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nx  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        quo_fix = sign_quo_q ? (~quo_nx) + WIDTH'(1) : quo_nx;
        rem_fix = sign_rem_q ? (~rem_nx) + WIDTH'(1) : rem_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            ready_q    <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (accept) begin
                        if (b == '0) begin
                            lo_q    <= '1;
                            hi_q    <= a;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            quo_q      <= a_abs;
                            div_q      <= b_abs;
                            rem_q      <= '0;
                            cnt_q      <= 6'd0;
                            sign_quo_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            sign_rem_q <= is_signed & a[WIDTH-1];
                            state_q    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cancel) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            lo_q    <= quo_fix;
                            hi_q    <= rem_fix;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The instruction that started us is still in EX here, so start is ignored.
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign lo_o  = lo_q;
    assign hi_o  = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;
    localparam logic [7:0] OP_ADD  = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  alucontrol = 8'd0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        stall_o;
    logic        ready;
    logic [31:0] lo_o;
    logic [31:0] hi_o;

    int errors = 0;
    int checks = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .alucontrol (alucontrol),
        .start      (start),
        .cancel     (cancel),
        .a          (a),
        .b          (b),
        .stall_o    (stall_o),
        .ready      (ready),
        .lo_o       (lo_o),
        .hi_o       (hi_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one divide at a negedge (cycle 0), hold start until the DONE edge has passed.
    task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_cyc);
        int cyc;
        int stall_cnt;
        @(negedge clk);
        alucontrol = op; a = av; b = bv; start = 1'b1; cancel = 1'b0;
        #1;
        check({tag, " stall c0"}, 32'(stall_o), 32'd1);
        cyc = 0;
        stall_cnt = 0;
        while (cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
            if (ready) break;
            if (stall_o) stall_cnt++;
        end
        check({tag, " ready cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " busy stalls"}, 32'(stall_cnt), 32'(exp_cyc - 1));
        check({tag, " stall done"}, 32'(stall_o), 32'd0);
        check({tag, " lo"}, lo_o, exp_lo);
        check({tag, " hi"}, hi_o, exp_hi);
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        check({tag, " idle stall"}, 32'(stall_o), 32'd0);
        check({tag, " idle ready"}, 32'(ready), 32'd0);
    endtask

    initial begin
        int ready_cnt;
        repeat (2) @(negedge clk);
        check("reset ready", 32'(ready), 32'd0);
        check("reset lo", lo_o, 32'd0);
        check("reset hi", hi_o, 32'd0);
        check("reset stall", 32'(stall_o), 32'd0);
        rst = 1'b0;

        run_div("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run_div("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        run_div("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
        run_div("divu 5/9", OP_DIVU, 32'd5, 32'd9, 32'd0, 32'd5, 33);
        run_div("divu big", OP_DIVU, 32'hF000_0000, 32'h0000_0010, 32'h0F00_0000, 32'd0, 33);
        run_div("divu dz", OP_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1);
        run_div("div dz", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);

        // Cancel mid-division: the previous (div-by-zero) result must survive.
        @(negedge clk);
        alucontrol = OP_DIV; a = 32'd50; b = 32'd5; start = 1'b1;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        #1;
        check("cancel stall", 32'(stall_o), 32'd0);
        ready_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (ready) ready_cnt++;
        end
        check("cancel no ready", 32'(ready_cnt), 32'd0);
        check("cancel lo hold", lo_o, 32'hFFFF_FFFF);
        check("cancel hi hold", hi_o, 32'hFFFF_FFF9);
        run_div("divu 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Cancel in the accept cycle and a non-divide code: no stall, no activity.
        @(negedge clk);
        alucontrol = OP_DIVU; a = 32'd40; b = 32'd4; start = 1'b1; cancel = 1'b1;
        #1;
        check("cancel accept stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        cancel = 1'b0; alucontrol = OP_ADD;
        #1;
        check("add stall", 32'(stall_o), 32'd0);
        ready_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (ready || stall_o) ready_cnt++;
        end
        start = 1'b0;
        check("add no activity", 32'(ready_cnt), 32'd0);
        check("add lo hold", lo_o, 32'd3);

        // Asynchronous reset between edges while busy.
        @(negedge clk);
        alucontrol = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst lo", lo_o, 32'd0);
        check("arst hi", hi_o, 32'd0);
        check("arst ready", 32'(ready), 32'd0);
        check("arst stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ready_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (ready || stall_o) ready_cnt++;
        end
        check("arst no ready", 32'(ready_cnt), 32'd0);
        run_div("divu after rst", OP_DIVU, 32'd1000, 32'd33, 32'd30, 32'd10, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
